// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data cache load/write-through port.
// Turns single-cycle word requests into 128-bit line commands on a
// ready/valid backend and returns one response per request, with a
// one-entry skid register for a request that arrives while busy.
module dcache_mem_responder #(
    parameter int unsigned MEM_SCALE  = 27,
    parameter int unsigned LINE_SCALE = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_oe,
    input  logic [MEM_SCALE-1:0]            req_addr,
    input  logic [31:0]                     req_wdata,
    input  logic [3:0]                      req_we,
    output logic [31:0]                     rsp_rdata,
    output logic                            rsp_valid,
    output logic                            rsp_written,
    output logic                            mem_cmd_valid,
    input  logic                            mem_cmd_ready,
    output logic                            mem_cmd_write,
    output logic [MEM_SCALE-LINE_SCALE-1:0] mem_cmd_addr,
    output logic [127:0]                    mem_wdata,
    output logic [15:0]                     mem_wmask,
    input  logic [127:0]                    mem_rdata,
    input  logic                            mem_rvalid,
    output logic                            err_overflow,
    output logic                            err_misalign,
    output logic                            err_stray,
    output logic [31:0]                     rd_cnt,
    output logic [31:0]                     wr_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [MEM_SCALE-1:0] cur_addr;
    logic [31:0]          cur_wdata;
    logic [3:0]           cur_we;

    logic                 skid_valid;
    logic [MEM_SCALE-1:0] skid_addr;
    logic [31:0]          skid_wdata;
    logic [3:0]           skid_we;

    logic [1:0]  cur_b;
    logic [1:0]  cur_l;
    logic [7:0]  cur_m;
    logic        cur_write;
    logic        cur_mis;
    logic [31:0] cur_word;

    // Byte/word lane decode of the current request
    always_comb begin
        cur_b     = cur_addr[1:0];
        cur_l     = cur_addr[3:2];
        cur_m     = {4'b0000, cur_we} << cur_b;
        cur_write = |cur_we;
        cur_mis   = |cur_m[7:4];
        cur_word  = cur_wdata << {cur_b, 3'b000};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    // A misaligned write spends its ISSUE cycle with the command suppressed,
    // so a response can never directly follow another response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_oe) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_mis) begin
                    state_nxt = RESP;
                end else if (mem_cmd_ready) begin
                    state_nxt = cur_write ? RESP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = (skid_valid || req_oe) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: command fields come straight from the current request
    always_comb begin
        mem_cmd_valid = (state == ISSUE) && !cur_mis;
        mem_cmd_write = cur_write;
        mem_cmd_addr  = cur_addr[MEM_SCALE-1:LINE_SCALE];
        mem_wmask     = cur_mis ? '0 : ({12'h000, cur_m[3:0]} << {cur_l, 2'b00});
        mem_wdata     = {96'h0, cur_word} << {cur_l, 5'b00000};
        rsp_valid     = (state == RESP) && !cur_write;
        rsp_written   = (state == RESP) && cur_write;
    end

    // Current-request and skid registers
    // A request arriving in RESP with the skid empty is loaded straight into
    // the current-request register: same order and timing as a skid hop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_we     <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_wdata <= '0;
            skid_we    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_oe) begin
                        cur_addr  <= req_addr;
                        cur_wdata <= req_wdata;
                        cur_we    <= req_we;
                    end
                end
                RESP: begin
                    if (skid_valid) begin
                        cur_addr   <= skid_addr;
                        cur_wdata  <= skid_wdata;
                        cur_we     <= skid_we;
                        skid_valid <= 1'b0;
                    end else if (req_oe) begin
                        cur_addr  <= req_addr;
                        cur_wdata <= req_wdata;
                        cur_we    <= req_we;
                    end
                end
                default: begin
                    if (req_oe && !skid_valid) begin
                        skid_addr  <= req_addr;
                        skid_wdata <= req_wdata;
                        skid_we    <= req_we;
                        skid_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read data capture, sticky error flags and completion counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata    <= '0;
            err_overflow <= 1'b0;
            err_misalign <= 1'b0;
            err_stray    <= 1'b0;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
        end else begin
            if (req_oe && (state != IDLE) && skid_valid) begin
                err_overflow <= 1'b1;
            end
            if ((state == ISSUE) && cur_mis) begin
                err_misalign <= 1'b1;
            end
            if (mem_rvalid) begin
                if (state == WAIT_RD) begin
                    rsp_rdata <= mem_rdata[{cur_l, 5'b00000} +: 32];
                end else begin
                    err_stray <= 1'b1;
                end
            end
            if (state == RESP) begin
                if (!cur_write) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end else if (!cur_mis) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Testbench for dcache_mem_responder: directed vector table, hand-written
// backpressure / skid / reset sequences, and a randomized run checked
// against a request-level reference model.
`timescale 1ns/1ps
module tb_dcache_mem_responder;

    logic         clk;
    logic         rst;
    logic         req_oe;
    logic [26:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_we;
    logic [31:0]  rsp_rdata;
    logic         rsp_valid;
    logic         rsp_written;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready;
    logic         mem_cmd_write;
    logic [22:0]  mem_cmd_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wmask;
    logic [127:0] mem_rdata;
    logic         mem_rvalid;
    logic         err_overflow;
    logic         err_misalign;
    logic         err_stray;
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;

    dcache_mem_responder #(.MEM_SCALE(27), .LINE_SCALE(4)) dut (
        .clk(clk), .rst(rst),
        .req_oe(req_oe), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .rsp_written(rsp_written),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .err_overflow(err_overflow), .err_misalign(err_misalign), .err_stray(err_stray),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0]  addr;
        logic [3:0]   we;
        logic [31:0]  wdata;
        logic [127:0] line;
        bit           mis;
        logic [22:0]  caddr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic [31:0]  rdata;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [26:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } req_t;

    int checks   = 0;
    int failures = 0;

    // backend behaviour knobs, written only by the main sequence
    int           ready_mode;   // 0 always ready, 1 random, 2 held low
    int           rd_lat_min;
    int           rd_lat_max;
    bit           fixed_line_en;
    logic [127:0] fixed_line;

    vec_t vt[9];
    req_t rsp_q[$];
    req_t cmd_q[$];
    int   exp_rd;
    int   exp_wr;
    bit   prev_rsp;
    bit   stalled;

    // memory contents seen by reads
    function automatic logic [127:0] line_of(input logic [22:0] la);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = {la, 9'(k)} ^ 32'h5A3C96E1;
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [26:0] a);
        logic [127:0] ln;
        ln = line_of(a[26:4]);
        return ln[int'(a[3:2])*32 +: 32];
    endfunction

    // byte-by-byte placement of a write into its line
    function automatic void exp_lanes(input req_t r, output logic [15:0] m,
                                      output logic [127:0] d, output bit mis);
        m = '0; d = '0; mis = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int p;
            p = int'(r.addr[1:0]) + i;
            if (r.we[i]) begin
                if (p > 3) mis = 1'b1;
                else begin
                    m[int'(r.addr[3:2])*4 + p] = 1'b1;
                    d[(int'(r.addr[3:2])*4 + p)*8 +: 8] = r.wdata[i*8 +: 8];
                end
            end
        end
    endfunction

    function automatic logic [127:0] bytes_of(input logic [15:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (m[i]) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, mem_cmd_valid, 0);
        chk({tag, "_cmd_write"}, mem_cmd_write, 0);
        chk({tag, "_cmd_addr"},  mem_cmd_addr, 0);
        chk({tag, "_wdata"},     mem_wdata, 0);
        chk({tag, "_wmask"},     mem_wmask, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_written"}, rsp_written, 0);
        chk({tag, "_err_overflow"}, err_overflow, 0);
        chk({tag, "_err_misalign"}, err_misalign, 0);
        chk({tag, "_err_stray"}, err_stray, 0);
        chk({tag, "_rd_cnt"}, rd_cnt, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, 0);
    endtask

    // per-cycle checks for the randomized run, sampled at the falling edge
    task automatic monitor();
        req_t e;
        logic [15:0] m;
        logic [127:0] d;
        bit mis;
        if (stalled) chk("stall_valid_held", mem_cmd_valid, 1);
        if (mem_cmd_valid) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", mem_cmd_valid, 0);
            end else begin
                e = cmd_q[0];
                exp_lanes(e, m, d, mis);
                chk("cmd_write", mem_cmd_write, e.wr);
                chk("cmd_addr", mem_cmd_addr, e.addr[26:4]);
                if (e.wr) begin
                    chk("cmd_wmask", mem_wmask, m);
                    chk("cmd_wdata", mem_wdata & bytes_of(m), d);
                end
                if (mem_cmd_ready) void'(cmd_q.pop_front());
            end
        end
        if (rsp_valid || rsp_written) begin
            chk("rsp_exclusive", rsp_valid && rsp_written, 0);
            chk("rsp_back_to_back", prev_rsp, 0);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_kind", rsp_written, e.wr);
                if (!e.wr) chk("rsp_rdata", rsp_rdata, exp_word(e.addr));
            end
        end
        prev_rsp = rsp_valid || rsp_written;
        stalled  = mem_cmd_valid && !mem_cmd_ready;
    endtask

    // backend model: ready per mode, one rvalid per accepted read after a latency
    initial begin : backend
        int          cd;
        bit          hs;
        bit          hs_wr;
        logic [22:0] hs_addr;
        logic [22:0] pend_addr;
        cd = 0;
        pend_addr = '0;
        mem_cmd_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            hs      = mem_cmd_valid && mem_cmd_ready;
            hs_wr   = mem_cmd_write;
            hs_addr = mem_cmd_addr;
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (hs && !hs_wr) begin
                cd = $urandom_range(rd_lat_max, rd_lat_min);
                pend_addr = hs_addr;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = fixed_line_en ? fixed_line : line_of(pend_addr);
                end
            end
            case (ready_mode)
                0:       mem_cmd_ready = 1'b1;
                1:       mem_cmd_ready = ($urandom_range(2, 0) != 0);
                default: mem_cmd_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t v;
        req_t r;
        bit wr;
        bit mis;
        logic [15:0] m;
        logic [127:0] d;
        logic [31:0] tmp;
        logic [31:0] got[2];
        int hs_cnt;
        int rsp_cnt;
        int n;

        vt[0] = '{27'h0001238, 4'h0, 32'h0, 128'h44444444_33333333_22222222_11111111,
                  1'b0, 23'h000123, 16'h0000, 128'h0, 32'h33333333};
        vt[1] = '{27'h0001006, 4'h3, 32'h0000BEEF, 128'h0,
                  1'b0, 23'h000100, 16'h00C0, 128'h00000000_00000000_BEEF0000_00000000, 32'h0};
        vt[2] = '{27'h0002003, 4'h3, 32'h0000BEEF, 128'h0,
                  1'b1, 23'h000200, 16'h0000, 128'h0, 32'h0};
        vt[3] = '{27'h000000C, 4'hF, 32'hCAFEF00D, 128'h0,
                  1'b0, 23'h000000, 16'hF000, 128'hCAFEF00D_00000000_00000000_00000000, 32'h0};
        vt[4] = '{27'h7FFFFF4, 4'h0, 32'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                  1'b0, 23'h7FFFFF, 16'h0000, 128'h0, 32'hFEDCBA98};
        vt[5] = '{27'h0000101, 4'h1, 32'h000000A5, 128'h0,
                  1'b0, 23'h000010, 16'h0002, 128'h00000000_00000000_00000000_0000A500, 32'h0};
        vt[6] = '{27'h0000102, 4'hC, 32'h12345678, 128'h0,
                  1'b1, 23'h000010, 16'h0000, 128'h0, 32'h0};
        vt[7] = '{27'h000010E, 4'h3, 32'h00001234, 128'h0,
                  1'b0, 23'h000010, 16'hC000, 128'h12340000_00000000_00000000_00000000, 32'h0};
        vt[8] = '{27'h0000000, 4'h0, 32'h0, 128'hDEADBEEF_00000000_00000000_600DF00D,
                  1'b0, 23'h000000, 16'h0000, 128'h0, 32'h600DF00D};

        rst = 1'b1; req_oe = 1'b0; req_addr = '0; req_wdata = '0; req_we = '0;
        ready_mode = 0; rd_lat_min = 1; rd_lat_max = 1;
        fixed_line_en = 1'b1; fixed_line = '0;
        exp_rd = 0; exp_wr = 0; prev_rsp = 1'b0; stalled = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // directed single transactions, backend ready at once, read data one cycle after accept
        for (int i = 0; i < 9; i++) begin
            v = vt[i];
            wr = (v.we != 4'h0);
            fixed_line = v.line;
            req_oe = 1'b1; req_addr = v.addr; req_we = v.we; req_wdata = v.wdata;
            tick();
            req_oe = 1'b0;
            @(negedge clk);
            chk("tbl_cmd_valid", mem_cmd_valid, !v.mis);
            if (!v.mis) begin
                chk("tbl_cmd_write", mem_cmd_write, wr);
                chk("tbl_cmd_addr", mem_cmd_addr, v.caddr);
                if (wr) begin
                    chk("tbl_wmask", mem_wmask, v.mask);
                    chk("tbl_wdata", mem_wdata & bytes_of(v.mask), v.data);
                end
            end
            tick();
            @(negedge clk);
            chk("tbl_t2_rsp_written", rsp_written, wr);
            chk("tbl_t2_rsp_valid", rsp_valid, 0);
            if (!wr) begin
                tick();
                @(negedge clk);
                chk("tbl_t3_rsp_valid", rsp_valid, 1);
                chk("tbl_t3_rsp_written", rsp_written, 0);
                chk("tbl_rsp_rdata", rsp_rdata, v.rdata);
                exp_rd++;
            end else if (!v.mis) begin
                exp_wr++;
            end
            tick();
            chk("tbl_rd_cnt", rd_cnt, exp_rd);
            chk("tbl_wr_cnt", wr_cnt, exp_wr);
        end
        chk("tbl_err_misalign", err_misalign, 1);
        chk("tbl_err_overflow", err_overflow, 0);
        chk("tbl_err_stray", err_stray, 0);

        // backpressure: ready held low five cycles while a write waits
        ready_mode = 2;
        hs_cnt = 0; rsp_cnt = 0;
        req_oe = 1'b1; req_addr = 27'h0003004; req_we = 4'hF; req_wdata = 32'h11223344;
        tick();
        req_oe = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", mem_cmd_valid, 1);
            chk("bp_write", mem_cmd_write, 1);
            chk("bp_addr", mem_cmd_addr, 23'h000300);
            chk("bp_wmask", mem_wmask, 16'h00F0);
            chk("bp_wdata", mem_wdata & bytes_of(16'h00F0), 128'h00000000_00000000_11223344_00000000);
            if (mem_cmd_valid && mem_cmd_ready) hs_cnt++;
            if (rsp_valid || rsp_written) rsp_cnt++;
            tick();
        end
        ready_mode = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_cmd_valid && mem_cmd_ready) hs_cnt++;
            if (rsp_valid || rsp_written) rsp_cnt++;
            tick();
        end
        exp_wr++;
        chk("bp_cmd_count", hs_cnt, 1);
        chk("bp_rsp_count", rsp_cnt, 1);
        chk("bp_wr_cnt", wr_cnt, exp_wr);

        // three reads on consecutive cycles while the first is stalled
        ready_mode = 2;
        fixed_line_en = 1'b0;
        hs_cnt = 0; n = 0; got[0] = '0; got[1] = '0;
        req_oe = 1'b1; req_we = 4'h0; req_wdata = '0;
        req_addr = 27'h000ABC0; tick();
        req_addr = 27'h1234568; tick();
        req_addr = 27'h0000010; tick();
        req_oe = 1'b0;
        tick();
        ready_mode = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_cmd_valid && mem_cmd_ready) hs_cnt++;
            if (rsp_valid) begin
                if (n < 2) got[n] = rsp_rdata;
                n++;
            end
            tick();
        end
        exp_rd += 2;
        chk("skid_rsp_count", n, 2);
        chk("skid_cmd_count", hs_cnt, 2);
        chk("skid_first_rdata", got[0], exp_word(27'h000ABC0));
        chk("skid_second_rdata", got[1], exp_word(27'h1234568));
        chk("skid_err_overflow", err_overflow, 1);
        chk("skid_rd_cnt", rd_cnt, exp_rd);

        // randomized traffic against the request-level model
        ready_mode = 1; rd_lat_min = 1; rd_lat_max = 3;
        rsp_q.delete(); cmd_q.delete();
        prev_rsp = 1'b0; stalled = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c < 550 && $urandom_range(99, 0) < 40) begin
                r.wr = ($urandom_range(1, 0) == 1);
                tmp = $urandom;
                r.addr = tmp[26:0];
                r.wdata = $urandom;
                if (r.wr) begin
                    tmp = $urandom_range(15, 1);
                    r.we = tmp[3:0];
                end else begin
                    r.we = 4'h0;
                    r.addr[1:0] = 2'b00;
                end
                req_oe = 1'b1; req_addr = r.addr; req_we = r.we; req_wdata = r.wdata;
                // at most two requests may be held, counting one responding this cycle
                if (rsp_q.size() < 2) begin
                    exp_lanes(r, m, d, mis);
                    rsp_q.push_back(r);
                    if (!mis) cmd_q.push_back(r);
                    if (!r.wr) exp_rd++;
                    else if (!mis) exp_wr++;
                end
            end else begin
                req_oe = 1'b0;
            end
            @(negedge clk);
            monitor();
            tick();
        end
        req_oe = 1'b0;
        for (int k = 0; k < 100 && rsp_q.size() != 0; k++) begin
            @(negedge clk);
            monitor();
            tick();
        end
        chk("rnd_drained", rsp_q.size(), 0);
        chk("rnd_rd_cnt", rd_cnt, exp_rd);
        chk("rnd_wr_cnt", wr_cnt, exp_wr);

        // reset while waiting for read data, then the late rvalid arrives
        ready_mode = 0; rd_lat_min = 4; rd_lat_max = 4;
        fixed_line_en = 1'b1; fixed_line = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
        repeat (4) tick();
        req_oe = 1'b1; req_addr = 27'h0000500; req_we = 4'h0; req_wdata = '0;
        tick();
        req_oe = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst = 1'b0;
        rsp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || rsp_written) rsp_cnt++;
            tick();
        end
        chk("rst_no_rsp", rsp_cnt, 0);
        chk("rst_err_stray", err_stray, 1);
        chk("rst_rdata_untouched", rsp_rdata, 0);
        chk("rst_rd_cnt", rd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
